// File: rtl/tt_cmd_pkg.sv
// Shared types and constants for the host command port: header layout,
// op codes, FSM states and default response bytes.
package tt_cmd_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'b00,
      OP_READ  = 2'b01,
      OP_PING  = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_DATA = 2'b01,
      ST_BUS  = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   localparam logic [7:0] PING_VALUE_DEF = 8'hA5;
   localparam logic [7:0] ERR_VALUE_DEF  = 8'hEE;

   localparam int HDR_OP_MSB   = 7;
   localparam int HDR_OP_LSB   = 6;
   localparam int HDR_ADDR_MSB = 5;
   localparam int HDR_ADDR_LSB = 0;

   function automatic op_e hdr_op(input logic [7:0] hdr);
      return op_e'(hdr[HDR_OP_MSB:HDR_OP_LSB]);
   endfunction

   function automatic logic [5:0] hdr_addr(input logic [7:0] hdr);
      return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
   endfunction

endpackage

// File: rtl/tt_host_cmd_port_sync.sv
// Request-toggle synchroniser: a SYNC_STAGES-deep flop chain plus the last
// accepted toggle level; pending stays high until the consumer accepts it.
module tt_toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_t,
   input  logic accept,
   output logic pending
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   level_q, level_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], req_t};
      if (accept) begin
         level_d = sync_q[SYNC_STAGES-1];
      end else begin
         level_d = level_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
      end
   end

   assign pending = sync_q[SYNC_STAGES-1] ^ level_q;

endmodule

// File: rtl/tt_host_cmd_port.sv
// Host pin-protocol responder: decodes toggle-flagged command bytes and
// runs register-bus reads/writes, answering through uo_out and an ack toggle.
module tt_host_cmd_port
   import tt_cmd_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] PING_VALUE  = PING_VALUE_DEF,
   parameter logic [7:0] ERR_VALUE   = ERR_VALUE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic       bus_req,
   output logic       bus_we,
   output logic [5:0] bus_addr,
   output logic [7:0] bus_wdata,
   input  logic       bus_gnt,
   input  logic [7:0] bus_rdata
);

   state_e     state_q, state_d;
   logic [7:0] uo_q, uo_d;
   logic       ack_q, ack_d;
   logic       bus_req_q, bus_req_d;
   logic       bus_we_q, bus_we_d;
   logic [5:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       pending_s;
   logic       accept_s;
   logic       unused_uio_s;

   assign unused_uio_s = ^uio_in[7:1];

   tt_toggle_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .req_t  (uio_in[0]),
      .accept (accept_s),
      .pending(pending_s)
   );

   // Requests arriving in BUS/RESP or while disabled simply remain pending.
   assign accept_s = pending_s && ena && ((state_q == ST_IDLE) || (state_q == ST_DATA));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (hdr_op(ui_in))
                  OP_WRITE: state_d = ST_DATA;
                  OP_READ:  state_d = ST_BUS;
                  default:  state_d = ST_IDLE;
               endcase
            end else begin
               state_d = state_q;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               state_d = ST_BUS;
            end else begin
               state_d = state_q;
            end
         end
         ST_BUS: begin
            if (bus_gnt) begin
               state_d = ST_RESP;
            end else begin
               state_d = state_q;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // uo_out only ever moves on the same edge as an ack toggle.
   always_comb begin
      uo_d      = uo_q;
      ack_d     = ack_q;
      bus_req_d = bus_req_q;
      bus_we_d  = bus_we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               addr_d = hdr_addr(ui_in);
               case (hdr_op(ui_in))
                  OP_WRITE: ack_d = ~ack_q;
                  OP_READ: begin
                     bus_we_d  = 1'b0;
                     bus_req_d = 1'b1;
                  end
                  OP_PING: begin
                     uo_d  = PING_VALUE;
                     ack_d = ~ack_q;
                  end
                  default: begin
                     uo_d  = ERR_VALUE;
                     ack_d = ~ack_q;
                  end
               endcase
            end else begin
               bus_req_d = 1'b0;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
               wdata_d   = ui_in;
               bus_we_d  = 1'b1;
               bus_req_d = 1'b1;
            end else begin
               bus_req_d = 1'b0;
            end
         end
         ST_BUS: begin
            if (bus_gnt) begin
               bus_req_d = 1'b0;
               ack_d     = ~ack_q;
               uo_d      = bus_we_q ? {2'b00, addr_q} : bus_rdata;
            end else begin
               bus_req_d = 1'b1;
            end
         end
         ST_RESP: bus_req_d = 1'b0;
         default: bus_req_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         uo_q      <= 8'h00;
         ack_q     <= 1'b0;
         bus_req_q <= 1'b0;
         bus_we_q  <= 1'b0;
         addr_q    <= 6'h00;
         wdata_q   <= 8'h00;
      end else begin
         uo_q      <= uo_d;
         ack_q     <= ack_d;
         bus_req_q <= bus_req_d;
         bus_we_q  <= bus_we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
      end
   end

   assign uo_out    = uo_q;
   assign uio_out   = {6'b00_0000, ack_q, 1'b0};
   assign uio_oe    = 8'b0000_0010;
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_tt_host_cmd_port.sv
// Directed, table-driven bench for tt_host_cmd_port with a small core-bus
// responder and hand-written sequences for enable gating and mid-bus reset.
module tb_tt_host_cmd_port;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic       req_t;
   logic [7:0] uio_in;
   logic [7:0] uo_out, uio_out, uio_oe;
   logic       bus_req, bus_we, bus_gnt;
   logic [5:0] bus_addr;
   logic [7:0] bus_wdata, bus_rdata;

   int pass_cnt  = 0;
   int total_cnt = 0;

   assign uio_in = {7'b0101010, req_t};

   always #5 clk = ~clk;

   tt_host_cmd_port dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .ui_in    (ui_in),
      .uio_in   (uio_in),
      .uo_out   (uo_out),
      .uio_out  (uio_out),
      .uio_oe   (uio_oe),
      .bus_req  (bus_req),
      .bus_we   (bus_we),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_gnt  (bus_gnt),
      .bus_rdata(bus_rdata)
   );

   // Core responder: grants after gnt_wait cycles of bus_req and logs the transfer.
   int         gnt_wait   = 0;
   logic [7:0] core_rdata = 8'h00;
   int         wait_cnt   = 0;
   int         txn_cnt    = 0;
   int         req_cycles = 0;
   logic       txn_we     = 1'b0;
   logic [5:0] txn_addr   = 6'h00;
   logic [7:0] txn_wdata  = 8'h00;
   initial begin
      bus_gnt   = 1'b0;
      bus_rdata = 8'h00;
   end
   always @(negedge clk) begin
      bus_rdata = core_rdata;
      if (bus_req === 1'b1) begin
         req_cycles++;
         if (wait_cnt >= gnt_wait) begin
            bus_gnt   = 1'b1;
            txn_cnt++;
            txn_we    = bus_we;
            txn_addr  = bus_addr;
            txn_wdata = bus_wdata;
         end else begin
            bus_gnt = 1'b0;
            wait_cnt++;
         end
      end else begin
         bus_gnt  = 1'b0;
         wait_cnt = 0;
      end
   end

   int   ack_cnt  = 0;
   logic ack_prev = 1'b0;
   always @(negedge clk) begin
      if (uio_out[1] !== ack_prev) ack_cnt++;
      ack_prev = uio_out[1];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   // Toggle one byte in and count rising edges until the ack level changes.
   task automatic host_send(input logic [7:0] b, output int lat);
      logic old_ack;
      @(negedge clk);
      ui_in   = b;
      req_t   = ~req_t;
      old_ack = uio_out[1];
      lat     = 99;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (uio_out[1] !== old_ack) begin
            lat = i;
            break;
         end
      end
   endtask

   typedef struct {
      logic [7:0] hdr;
      logic [7:0] data;
      bit         two;
      int         gw;
      logic [7:0] rdata;
      logic [7:0] exp_uo;
      int         exp_lat;
      int         exp_txn;
      logic       exp_we;
      logic [5:0] exp_addr;
      logic [7:0] exp_wdata;
      int         exp_req;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int lat;
      int base_txn, base_req, base_ack;

      vecs[0] = '{8'h80, 8'h00, 1'b0, 0, 8'h00, 8'hA5, 3, 0, 1'b0, 6'h00, 8'h00, 0};
      vecs[1] = '{8'h05, 8'h3C, 1'b1, 2, 8'h00, 8'h05, 6, 1, 1'b1, 6'h05, 8'h3C, 3};
      vecs[2] = '{8'h45, 8'h00, 1'b0, 0, 8'h9B, 8'h9B, 4, 1, 1'b0, 6'h05, 8'h00, 1};
      vecs[3] = '{8'hC0, 8'h00, 1'b0, 0, 8'h00, 8'hEE, 3, 0, 1'b0, 6'h00, 8'h00, 0};
      vecs[4] = '{8'h7F, 8'h00, 1'b0, 1, 8'h5A, 8'h5A, 5, 1, 1'b0, 6'h3F, 8'h00, 2};
      vecs[5] = '{8'h3F, 8'hFF, 1'b1, 0, 8'h00, 8'h3F, 4, 1, 1'b1, 6'h3F, 8'hFF, 1};
      vecs[6] = '{8'hFF, 8'h00, 1'b0, 0, 8'h00, 8'hEE, 3, 0, 1'b0, 6'h00, 8'h00, 0};

      rst_n = 1'b0;
      req_t = 1'b0;
      ena   = 1'b1;
      ui_in = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_uo", {24'h0, uo_out}, 32'h00);
      check("rst_uio_out", {24'h0, uio_out}, 32'h00);
      check("rst_uio_oe", {24'h0, uio_oe}, 32'h02);
      check("rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("rst_bus_we", {31'h0, bus_we}, 32'h0);
      check("rst_bus_addr", {26'h0, bus_addr}, 32'h0);
      check("rst_bus_wdata", {24'h0, bus_wdata}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         gnt_wait   = vecs[i].gw;
         core_rdata = vecs[i].rdata;
         base_txn   = txn_cnt;
         base_req   = req_cycles;
         host_send(vecs[i].hdr, lat);
         if (vecs[i].two) begin
            check($sformatf("v%0d_hdr_lat", i), lat, 32'd3);
            host_send(vecs[i].data, lat);
         end
         check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         repeat (3) @(negedge clk);
         check($sformatf("v%0d_uo", i), {24'h0, uo_out}, {24'h0, vecs[i].exp_uo});
         check($sformatf("v%0d_txn", i), txn_cnt - base_txn, vecs[i].exp_txn);
         check($sformatf("v%0d_req_cyc", i), req_cycles - base_req, vecs[i].exp_req);
         check($sformatf("v%0d_uio_other", i), {24'h0, uio_out & 8'hFD}, 32'h0);
         if (vecs[i].exp_txn != 0) begin
            check($sformatf("v%0d_we", i), {31'h0, txn_we}, {31'h0, vecs[i].exp_we});
            check($sformatf("v%0d_addr", i), {26'h0, txn_addr}, {26'h0, vecs[i].exp_addr});
            if (vecs[i].exp_we) begin
               check($sformatf("v%0d_wdata", i), {24'h0, txn_wdata}, {24'h0, vecs[i].exp_wdata});
            end
         end
      end

      // Ping while disabled must wait, then be taken exactly once.
      gnt_wait = 0;
      @(negedge clk);
      ena      = 1'b0;
      base_ack = ack_cnt;
      @(negedge clk);
      ui_in = 8'h80;
      req_t = ~req_t;
      repeat (10) @(negedge clk);
      check("ena0_no_ack", ack_cnt - base_ack, 32'd0);
      check("ena0_uo_held", {24'h0, uo_out}, 32'hEE);
      ena = 1'b1;
      repeat (10) @(negedge clk);
      check("ena1_one_ack", ack_cnt - base_ack, 32'd1);
      check("ena1_uo", {24'h0, uo_out}, 32'hA5);

      // Reset while a read is stalled on the bus.
      if (uio_out[1] == 1'b0) begin
         host_send(8'h80, lat);
      end
      check("pre_rst_ack", {31'h0, uio_out[1]}, 32'h1);
      gnt_wait = 1000;
      @(negedge clk);
      ui_in = 8'h41;
      req_t = ~req_t;
      for (int i = 0; i < 20 && bus_req !== 1'b1; i++) @(negedge clk);
      check("stall_bus_req", {31'h0, bus_req}, 32'h1);
      #2;
      rst_n = 1'b0;
      req_t = 1'b0;
      #1;
      check("async_rst_bus_req", {31'h0, bus_req}, 32'h0);
      check("async_rst_uo", {24'h0, uo_out}, 32'h00);
      check("async_rst_ack", {31'h0, uio_out[1]}, 32'h0);
      check("async_rst_addr", {26'h0, bus_addr}, 32'h0);
      gnt_wait = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      host_send(8'h80, lat);
      check("post_rst_ping_lat", lat, 32'd3);
      check("post_rst_ping_uo", {24'h0, uo_out}, 32'hA5);
      check("post_rst_ping_ack", {31'h0, uio_out[1]}, 32'h1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
